// File: rtl/rc4_key_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : rc4_key_scheduler_if
//  Description : Scheduler <-> decrypt-core bundle: chunk requests, per-core
//                status and found keys, one-hot grants with the key range,
//                and the global halt.
//  Revision    : 1.0  initial release
// ============================================================================
interface rc4_key_scheduler_if #(
  parameter int NUM_CORES = 4,
  parameter int KEY_WIDTH = 24
);
  logic [NUM_CORES-1:0]           req;
  logic [NUM_CORES-1:0]           core_idle;
  logic [NUM_CORES-1:0]           core_found;
  logic [NUM_CORES*KEY_WIDTH-1:0] core_key;
  logic [NUM_CORES-1:0]           grant;
  logic [KEY_WIDTH-1:0]           grant_first;
  logic [KEY_WIDTH-1:0]           grant_last;
  logic                           halt;

  // Scheduler side: consumes core status, hands out chunks.
  modport master (
    input  req, core_idle, core_found, core_key,
    output grant, grant_first, grant_last, halt
  );

  // Core side: raises requests and status, receives chunks.
  modport slave (
    output req, core_idle, core_found, core_key,
    input  grant, grant_first, grant_last, halt
  );
endinterface
`default_nettype wire

// File: rtl/rc4_key_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : rc4_key_scheduler
//  Description : Hands RC4 key-space chunks of 2**CHUNK_LOG2 keys to
//                NUM_CORES cores round-robin, watches per-core found/idle
//                status, latches the winning key and raises halt.
//                Optional macro RC4_SCHED_STATS_EN adds chunks_issued_o and
//                search_cycles_o saturating counters.
//  Revision    : 1.0  initial release
// ============================================================================
module rc4_key_scheduler #(
  parameter int                   NUM_CORES  = 4,
  parameter int                   KEY_WIDTH  = 24,
  parameter logic [KEY_WIDTH-1:0] KEY_MAX    = 24'h3FFFFF,
  parameter int                   CHUNK_LOG2 = 12
) (
  input  wire logic                 clock_i,
  input  wire logic                 reset_i,
  input  wire logic                 start_i,
  rc4_key_scheduler_if.master       core_if,
  output logic                      found_o,
  output logic                      not_found_o,
  output logic [KEY_WIDTH-1:0]      result_key_o,
  output logic                      busy_o
`ifdef RC4_SCHED_STATS_EN
  ,
  output logic [KEY_WIDTH-CHUNK_LOG2:0] chunks_issued_o,
  output logic [31:0]                   search_cycles_o
`endif
);

  localparam int PTR_W  = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  // One extra bit so stepping past KEY_MAX can never wrap back into range.
  localparam int BASE_W = KEY_WIDTH + 1;
  localparam logic [BASE_W-1:0] C_CHUNK   = BASE_W'(1) << CHUNK_LOG2;
  localparam logic [BASE_W-1:0] C_KEY_MAX = {1'b0, KEY_MAX};

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_DISPATCH  = 3'd1,
    S_DRAIN     = 3'd2,
    S_FOUND     = 3'd3,
    S_EXHAUSTED = 3'd4
  } state_t;

  state_t               state_q,       state_d;
  logic [BASE_W-1:0]    next_base_q,   next_base_d;
  logic [PTR_W-1:0]     rr_ptr_q,      rr_ptr_d;
  logic [NUM_CORES-1:0] grant_q,       grant_d;
  logic [KEY_WIDTH-1:0] grant_first_q, grant_first_d;
  logic [KEY_WIDTH-1:0] grant_last_q,  grant_last_d;
  logic [KEY_WIDTH-1:0] result_key_q,  result_key_d;

  logic [NUM_CORES-1:0] w_hi_mask;
  logic [NUM_CORES-1:0] w_req_hi;
  logic [NUM_CORES-1:0] w_pick_src;
  logic [NUM_CORES-1:0] w_pick_oh;
  logic [NUM_CORES-1:0] w_found_oh;
  logic [PTR_W-1:0]     w_idx_chain [NUM_CORES+1];
  logic [KEY_WIDTH-1:0] w_key_chain [NUM_CORES+1];
  logic [PTR_W-1:0]     w_pick_idx;
  logic [PTR_W-1:0]     w_rr_next;
  logic [KEY_WIDTH-1:0] w_found_key;
  logic                 w_any_found;
  logic                 w_any_req;
  logic                 w_start_accept;
  logic [BASE_W-1:0]    w_base_step;
  logic [BASE_W-1:0]    w_last_raw;
  logic [KEY_WIDTH-1:0] w_last_clip;

  // Round-robin pick: lowest request at or above rr_ptr, else lowest overall.
  assign w_hi_mask  = ~((NUM_CORES'(1) << rr_ptr_q) - NUM_CORES'(1));
  assign w_req_hi   = core_if.req & w_hi_mask;
  assign w_pick_src = (|w_req_hi) ? w_req_hi : core_if.req;
  assign w_pick_oh  = w_pick_src & (~w_pick_src + NUM_CORES'(1));
  assign w_any_req  = |core_if.req;

  // Lowest-indexed found core owns the result.
  assign w_found_oh  = core_if.core_found & (~core_if.core_found + NUM_CORES'(1));
  assign w_any_found = |core_if.core_found;

  assign w_idx_chain[0] = '0;
  assign w_key_chain[0] = '0;
  for (genvar g = 0; g < NUM_CORES; g++) begin : g_core
    assign w_idx_chain[g+1] = w_idx_chain[g] | (w_pick_oh[g] ? PTR_W'(g) : '0);
    assign w_key_chain[g+1] = w_key_chain[g] |
                              (w_found_oh[g] ? core_if.core_key[g*KEY_WIDTH +: KEY_WIDTH] : '0);
  end

  assign w_pick_idx  = w_idx_chain[NUM_CORES];
  assign w_found_key = w_key_chain[NUM_CORES];
  assign w_rr_next   = w_pick_oh[NUM_CORES-1] ? '0 : w_pick_idx + PTR_W'(1);

  // Chunk bounds; the last key of the final chunk is clipped to KEY_MAX.
  assign w_base_step = next_base_q + C_CHUNK;
  assign w_last_raw  = w_base_step - BASE_W'(1);
  assign w_last_clip = (w_last_raw > C_KEY_MAX) ? KEY_MAX : w_last_raw[KEY_WIDTH-1:0];

  assign w_start_accept = start_i && ((state_q == S_IDLE)  ||
                                      (state_q == S_FOUND) ||
                                      (state_q == S_EXHAUSTED));

  // Next-state and grant decision; found always pre-empts a grant.
  always_comb begin
    state_d       = state_q;
    next_base_d   = next_base_q;
    rr_ptr_d      = rr_ptr_q;
    grant_d       = '0;
    grant_first_d = grant_first_q;
    grant_last_d  = grant_last_q;
    result_key_d  = result_key_q;
    case (state_q)
      S_IDLE, S_FOUND, S_EXHAUSTED: begin
        if (w_start_accept) begin
          state_d     = S_DISPATCH;
          next_base_d = '0;
          rr_ptr_d    = '0;
        end
      end
      S_DISPATCH: begin
        if (w_any_found) begin
          state_d      = S_FOUND;
          result_key_d = w_found_key;
        end else if (w_any_req && (grant_q == '0)) begin
          // A granted core still shows req during its grant pulse, so the
          // cycle after a grant never issues another one.
          grant_d       = w_pick_oh;
          grant_first_d = next_base_q[KEY_WIDTH-1:0];
          grant_last_d  = w_last_clip;
          next_base_d   = w_base_step;
          rr_ptr_d      = w_rr_next;
          if (w_base_step > C_KEY_MAX) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (w_any_found) begin
          state_d      = S_FOUND;
          result_key_d = w_found_key;
        end else if (&core_if.core_idle) begin
          state_d = S_EXHAUSTED;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q       <= S_IDLE;
      next_base_q   <= '0;
      rr_ptr_q      <= '0;
      grant_q       <= '0;
      grant_first_q <= '0;
      grant_last_q  <= '0;
      result_key_q  <= '0;
    end else begin
      state_q       <= state_d;
      next_base_q   <= next_base_d;
      rr_ptr_q      <= rr_ptr_d;
      grant_q       <= grant_d;
      grant_first_q <= grant_first_d;
      grant_last_q  <= grant_last_d;
      result_key_q  <= result_key_d;
    end
  end

  assign core_if.grant       = grant_q;
  assign core_if.grant_first = grant_first_q;
  assign core_if.grant_last  = grant_last_q;
  assign found_o             = (state_q == S_FOUND);
  assign core_if.halt        = found_o;
  assign not_found_o         = (state_q == S_EXHAUSTED);
  assign result_key_o        = result_key_q;
  assign busy_o              = (state_q == S_DISPATCH) || (state_q == S_DRAIN);

`ifdef RC4_SCHED_STATS_EN
  localparam int CNT_W = KEY_WIDTH - CHUNK_LOG2 + 1;

  logic [CNT_W-1:0] chunks_q, chunks_d;
  logic [31:0]      cycles_q, cycles_d;

  // Saturating grant and busy-cycle counters, cleared by an accepted start.
  always_comb begin
    chunks_d = chunks_q;
    cycles_d = cycles_q;
    if (w_start_accept) begin
      chunks_d = '0;
      cycles_d = '0;
    end else begin
      if ((grant_d != '0) && (chunks_q != {CNT_W{1'b1}})) begin
        chunks_d = chunks_q + CNT_W'(1);
      end
      if (busy_o && (cycles_q != 32'hFFFF_FFFF)) begin
        cycles_d = cycles_q + 32'd1;
      end
    end
  end

  // Statistics registers.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      chunks_q <= '0;
      cycles_q <= '0;
    end else begin
      chunks_q <= chunks_d;
      cycles_q <= cycles_d;
    end
  end

  assign chunks_issued_o = chunks_q;
  assign search_cycles_o = cycles_q;
`endif

endmodule
`default_nettype wire
